// File: rtl/alu8_cmd_sequencer.sv
// alu8_cmd_sequencer
// Byte-serial command front end for the 8-bit ALU datapath.
// It accepts an opcode byte and operand bytes on a valid/ready input stream,
// drives registered operands and control into the combinational ALU, waits
// EXEC_WAIT cycles for it to settle, and returns the result byte and then the
// flags byte ({4'b0, Z, N, C, V}) on a valid/ready output stream.
//
// Opcode byte: [2:0] ALUControl, [3] CHAIN, [7:4] reserved.
// Optional feature macro: ALU_SEQ_CHAIN_EN
//   defined   -> CHAIN=1 skips the A byte and reuses the last captured result.
//   undefined -> CHAIN is ignored and A always comes from the stream.
module alu8_cmd_sequencer #(
  parameter int unsigned EXEC_WAIT = 1   // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_ctrl,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_neg,
  input  logic       alu_carry,
  input  logic       alu_ovf,
  output logic       busy
);

  localparam logic [3:0] WAIT_INIT = 4'(EXEC_WAIT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_A   = 3'd1,
    GET_B   = 3'd2,
    EXEC    = 3'd3,
    OUT_RES = 3'd4,
    OUT_FLG = 3'd5
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [3:0] wait_cnt;
  logic [7:0] res;
  logic [7:0] flg;

  logic       load_ctrl;
  logic       load_a;
  logic       load_b;
  logic       cnt_dec;
  logic       capture;
  logic       send_flg;
  logic       in_stage;

`ifdef ALU_SEQ_CHAIN_EN
  logic       load_a_chain;
  logic       unused_bits;
  assign unused_bits = ^in_data[7:4];
`else
  logic       unused_bits;
  assign unused_bits = ^{in_data[7:3], res};
`endif

  // in_ready is a pure state decode, forced low while reset is asserted so
  // nothing upstream sees a ready sequencer before it can actually accept.
  assign in_ready  = in_stage & rst_n;
  assign out_valid = (state == OUT_RES) || (state == OUT_FLG);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the load strobes that steer the datapath registers.
  always_comb begin
    state_next = state;
    in_stage   = 1'b0;
    load_ctrl  = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    cnt_dec    = 1'b0;
    capture    = 1'b0;
    send_flg   = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    load_a_chain = 1'b0;
`endif
    case (state)
      IDLE: begin
        in_stage = 1'b1;
        if (in_valid) begin
          load_ctrl = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
          if (in_data[3]) begin
            load_a_chain = 1'b1;
            state_next   = GET_B;
          end else begin
            state_next = GET_A;
          end
`else
          state_next = GET_A;
`endif
        end
      end
      GET_A: begin
        in_stage = 1'b1;
        if (in_valid) begin
          load_a     = 1'b1;
          state_next = GET_B;
        end
      end
      GET_B: begin
        in_stage = 1'b1;
        if (in_valid) begin
          load_b     = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        cnt_dec = 1'b1;
        if (wait_cnt <= 4'd1) begin
          capture    = 1'b1;
          state_next = OUT_RES;
        end
      end
      OUT_RES: begin
        if (out_ready) begin
          send_flg   = 1'b1;
          state_next = OUT_FLG;
        end
      end
      OUT_FLG: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand and control registers; they hold until the next command reloads them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl <= 3'd0;
      alu_a    <= 8'd0;
      alu_b    <= 8'd0;
    end else begin
      if (load_ctrl) begin
        alu_ctrl <= in_data[2:0];
      end
`ifdef ALU_SEQ_CHAIN_EN
      if (load_a_chain) begin
        alu_a <= res;
      end else if (load_a) begin
        alu_a <= in_data;
      end
`else
      if (load_a) begin
        alu_a <= in_data;
      end
`endif
      if (load_b) begin
        alu_b <= in_data;
      end
    end
  end

  // Settle counter: loaded with the B byte, counted down while in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if (load_b) begin
      wait_cnt <= WAIT_INIT;
    end else if (cnt_dec && (wait_cnt != 4'd0)) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Result/flag capture and the output byte, which only changes on a load so
  // it stays stable while the downstream side is stalling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res      <= 8'd0;
      flg      <= 8'd0;
      out_data <= 8'd0;
    end else if (capture) begin
      res      <= alu_result;
      flg      <= {4'b0000, alu_zero, alu_neg, alu_carry, alu_ovf};
      out_data <= alu_result;
    end else if (send_flg) begin
      out_data <= flg;
    end
  end

endmodule

// File: tb/tb_alu8_cmd_sequencer.sv
// tb_alu8_cmd_sequencer
// Self-checking bench for alu8_cmd_sequencer. A behavioural ALU model drives
// the ALU inputs of the sequencer; expected bytes come from a hand-computed
// vector table and, for random traffic, from a transaction-level model.
// Build with +define+ALU_SEQ_CHAIN_EN to exercise the chaining feature.
module tb_alu8_cmd_sequencer;

  localparam int EW     = 3;
  localparam int BUDGET = 200;
`ifdef ALU_SEQ_CHAIN_EN
  localparam bit CHAIN_EN = 1'b1;
`else
  localparam bit CHAIN_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_neg;
  logic       alu_carry;
  logic       alu_ovf;
  logic       busy;

  int  total_checks = 0;
  int  bad_checks   = 0;
  bit  random_gaps  = 1'b0;
  logic [7:0] model_res = 8'h00;

  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] flg;
  } vec_t;

  vec_t vecs[6];

  alu8_cmd_sequencer #(.EXEC_WAIT(EW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .alu_carry  (alu_carry),
    .alu_ovf    (alu_ovf),
    .busy       (busy)
  );

  // Behavioural ALU: returns {Z, N, C, V, result}. C is always the adder
  // carry-out (A + B, or A + ~B + 1 for ctrl[2]); V is the adder overflow for ADD/SUB.
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] ctrl);
    logic [7:0] bm;
    logic [8:0] sum;
    logic [7:0] r;
    logic       z, n, c, v;
    bm  = ctrl[2] ? ~b : b;
    sum = {1'b0, a} + {1'b0, bm} + {8'd0, ctrl[2]};
    case (ctrl)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = sum[7:0];
      3'b011:  r = a ^ b;
      3'b100:  r = a & ~b;
      3'b101:  r = a | ~b;
      3'b110:  r = sum[7:0];
      default: r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
    endcase
    c = sum[8];
    v = (ctrl[1:0] == 2'b10) && (a[7] == bm[7]) && (sum[7] != a[7]);
    z = (r == 8'd0);
    n = r[7];
    return {z, n, c, v, r};
  endfunction

  logic [11:0] alu_out;
  assign alu_out = alu_model(alu_a, alu_b, alu_ctrl);
  assign {alu_zero, alu_neg, alu_carry, alu_ovf, alu_result} = alu_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=expired required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    if (random_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("send_handshake", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic recvByte(output logic [7:0] b);
    int n;
    if (random_gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    n = 0;
    while (!out_valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("recv_handshake", {15'd0, out_valid}, 16'd1);
    b = out_data;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // One full command. Expected bytes come from the table when use_exp is set,
  // otherwise from the ALU model applied to the effective operands.
  task automatic applyStimulus(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                               input bit use_exp, input logic [7:0] exp_res,
                               input logic [7:0] exp_flg, input string tag);
    logic        chain;
    logic [7:0]  a_eff;
    logic [11:0] m;
    logic [7:0]  want_res, want_flg, got_res, got_flg;
    chain = CHAIN_EN && op[3];
    a_eff = chain ? model_res : a;
    m = alu_model(a_eff, b, op[2:0]);
    want_res = use_exp ? exp_res : m[7:0];
    want_flg = use_exp ? exp_flg : {4'b0000, m[11:8]};
    sendByte(op);
    if (!chain) sendByte(a);
    sendByte(b);
    recvByte(got_res);
    checkOutput({tag, " hold_a"}, {8'd0, alu_a}, {8'd0, a_eff});
    checkOutput({tag, " hold_b"}, {8'd0, alu_b}, {8'd0, b});
    checkOutput({tag, " hold_ctrl"}, {13'd0, alu_ctrl}, {13'd0, op[2:0]});
    recvByte(got_flg);
    checkOutput({tag, " res"}, {8'd0, got_res}, {8'd0, want_res});
    checkOutput({tag, " flg"}, {8'd0, got_flg}, {8'd0, want_flg});
    checkOutput({tag, " busy_after"}, {15'd0, busy}, 16'd0);
    model_res = want_res;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " in_ready"}, {15'd0, in_ready}, 16'd0);
    checkOutput({tag, " out_valid"}, {15'd0, out_valid}, 16'd0);
    checkOutput({tag, " busy"}, {15'd0, busy}, 16'd0);
    checkOutput({tag, " out_data"}, {8'd0, out_data}, 16'd0);
    checkOutput({tag, " alu_a"}, {8'd0, alu_a}, 16'd0);
    checkOutput({tag, " alu_b"}, {8'd0, alu_b}, 16'd0);
    checkOutput({tag, " alu_ctrl"}, {13'd0, alu_ctrl}, 16'd0);
  endtask

  initial begin
    logic [7:0] r, f;
    int n;

    vecs[0] = '{op: 8'h02, a: 8'h7F, b: 8'h01, res: 8'h80, flg: 8'h05};
    vecs[1] = '{op: 8'h06, a: 8'h05, b: 8'h05, res: 8'h00, flg: 8'h0A};
    vecs[2] = '{op: 8'h00, a: 8'hF0, b: 8'h3C, res: 8'h30, flg: 8'h02};
    vecs[3] = '{op: 8'h01, a: 8'h0F, b: 8'hF0, res: 8'hFF, flg: 8'h04};
    vecs[4] = '{op: 8'h12, a: 8'hFF, b: 8'h01, res: 8'h00, flg: 8'h0A};
    vecs[5] = '{op: 8'h06, a: 8'h80, b: 8'h01, res: 8'h7F, flg: 8'h03};

    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    #1;
    checkOutput("release in_ready", {15'd0, in_ready}, 16'd1);

    // Latency: out_valid must rise exactly EW edges after the B byte is taken.
    sendByte(8'h02);
    sendByte(8'h7F);
    sendByte(8'h01);
    checkOutput("lat alu_ctrl", {13'd0, alu_ctrl}, 16'h0002);
    for (int i = 0; i <= EW; i++) begin
      @(negedge clk);
      checkOutput($sformatf("latency_%0d", i), {15'd0, out_valid}, (i == EW) ? 16'd1 : 16'd0);
    end
    recvByte(r);
    recvByte(f);
    checkOutput("lat res", {8'd0, r}, 16'h0080);
    checkOutput("lat flg", {8'd0, f}, 16'h0005);
    model_res = 8'h80;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].flg,
                    $sformatf("vec%0d", i));
    end

    // Backpressure with in_valid held high: output must hold, nothing consumed.
    sendByte(8'h02);
    sendByte(8'h7F);
    sendByte(8'h01);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp out_valid rise", {15'd0, out_valid}, 16'd1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d out_data", i), {8'd0, out_data}, 16'h0080);
      checkOutput($sformatf("bp%0d in_ready", i), {15'd0, in_ready}, 16'd0);
      checkOutput($sformatf("bp%0d out_valid", i), {15'd0, out_valid}, 16'd1);
    end
    in_valid = 1'b0;
    recvByte(r);
    recvByte(f);
    checkOutput("bp res", {8'd0, r}, 16'h0080);
    checkOutput("bp flg", {8'd0, f}, 16'h0005);
    model_res = 8'h80;
    @(negedge clk);
    checkOutput("bp idle in_ready", {15'd0, in_ready}, 16'd1);

    // Chaining: 0x0A takes A from the previous result when the feature is built in.
    applyStimulus(8'h02, 8'h7F, 8'h01, 1'b1, 8'h80, 8'h05, "pre_chain");
`ifdef ALU_SEQ_CHAIN_EN
    applyStimulus(8'h0A, 8'h00, 8'h01, 1'b1, 8'h81, 8'h04, "chain");
`else
    sendByte(8'h0A);
    sendByte(8'h01);
    repeat (4) @(negedge clk);
    checkOutput("nochain busy", {15'd0, busy}, 16'd1);
    checkOutput("nochain in_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("nochain out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("nochain alu_a", {8'd0, alu_a}, 16'h0001);
    sendByte(8'h01);
    recvByte(r);
    recvByte(f);
    checkOutput("nochain res", {8'd0, r}, 16'h0002);
    checkOutput("nochain flg", {8'd0, f}, 16'h0000);
    model_res = 8'h02;
`endif

    // Reset after only the A byte: everything clears asynchronously.
    sendByte(8'h06);
    sendByte(8'h33);
    checkOutput("midrst alu_a before", {8'd0, alu_a}, 16'h0033);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_res = 8'h00;
    #1;
    checkOutput("midrst release in_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("midrst no output", {15'd0, out_valid}, 16'd0);
    applyStimulus(8'h06, 8'h05, 8'h05, 1'b1, 8'h00, 8'h0A, "post_rst");

    // Randomized commands with random handshake gaps, checked by the model.
    random_gaps = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 8'h00, 8'h00,
                    $sformatf("rnd%0d", i));
    end
    random_gaps = 1'b0;

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
